gtf_common_qpll_seq: RTL

- Parametrised power-up/reset/lock sequencer for NUM_PLL QPLLs, i.e. the QPLL0/QPLL1 pairs across one or more GTF_COMMON sites.
- Sits beside the GTF common wrappers in the DRP clock domain and drives each QPLL's pd/reset pins.
- Monitors lock and refclk-lost per PLL, with timeout, bounded retry, lock-loss recovery and a sticky fail state.

---
 rtl/gtf_common_qpll_seq.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/gtf_common_qpll_seq.sv
// Power-up / reset / lock sequencer for NUM_PLL QPLLs in the GTF common DRP clock domain.
// Ports: gtf_cm_drpclk/gtf_cm_rstn clock and async reset; seq_start level run enable;
//   qpll_lock_in/qpll_refclklost_in raw async status; qpll_pd_out/qpll_reset_out to the QPLL;
//   qpll_locked, qpll_fail (sticky), qpll_lost_pulse, qpll_retry_cnt (4 bits per PLL), all_locked.
module gtf_common_qpll_seq #(
    parameter int                 NUM_PLL            = 2,
    parameter logic [NUM_PLL-1:0] PLL_EN             = {NUM_PLL{1'b1}},
    parameter int                 PD_CYCLES          = 64,
    parameter int                 RESET_CYCLES       = 128,
    parameter int                 LOCK_TIMEOUT       = 250000,
    parameter int                 LOCK_STABLE_CYCLES = 1024,
    parameter int                 MAX_RETRY          = 3
) (
    input  logic                   gtf_cm_drpclk,
    input  logic                   gtf_cm_rstn,
    input  logic                   seq_start,
    input  logic [NUM_PLL-1:0]     qpll_lock_in,
    input  logic [NUM_PLL-1:0]     qpll_refclklost_in,
    output logic [NUM_PLL-1:0]     qpll_pd_out,
    output logic [NUM_PLL-1:0]     qpll_reset_out,
    output logic [NUM_PLL-1:0]     qpll_locked,
    output logic [NUM_PLL-1:0]     qpll_fail,
    output logic [NUM_PLL-1:0]     qpll_lost_pulse,
    output logic [4*NUM_PLL-1:0]   qpll_retry_cnt,
    output logic                   all_locked
);

    localparam int CNT_MAX = (PD_CYCLES > RESET_CYCLES) ? PD_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    // The lock sample that moves WAIT_LOCK to STABLE is the first of the run,
    // so STABLE needs LOCK_STABLE_CYCLES-1 further lock samples.
    localparam logic [STB_W-1:0] STB_LAST =
        STB_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_PD, S_RST, S_WAIT, S_STABLE, S_LOCKED, S_FAIL
    } state_t;

    logic [NUM_PLL-1:0] lk_meta, lk, rl_meta, rl;

    always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_rstn) begin
        if (!gtf_cm_rstn) begin
            lk_meta <= '0;
            lk      <= '0;
            rl_meta <= '0;
            rl      <= '0;
        end else begin
            lk_meta <= qpll_lock_in;
            lk      <= lk_meta;
            rl_meta <= qpll_refclklost_in;
            rl      <= rl_meta;
        end
    end

    for (genvar i = 0; i < NUM_PLL; i++) begin : g_pll
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic [TMO_W-1:0] tmo;
        logic [STB_W-1:0] stab;
        logic [3:0]       retry;
        logic             pd, rst, locked, fail, lost;
        logic             at_max;
        logic [3:0]       retry_inc;
        state_t           retry_state;

        assign at_max      = (retry == RETRY_MAX);
        assign retry_inc   = (retry == 4'hF) ? retry : retry + 4'd1;
        assign retry_state = at_max ? S_FAIL : S_PD;

        always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_rstn) begin
            if (!gtf_cm_rstn) begin
                state  <= S_IDLE;
                cnt    <= '0;
                tmo    <= '0;
                stab   <= '0;
                retry  <= '0;
                pd     <= 1'b1;
                rst    <= 1'b1;
                locked <= 1'b0;
                fail   <= 1'b0;
                lost   <= 1'b0;
            end else begin
                lost <= 1'b0;
                if (!seq_start) begin
                    state  <= S_IDLE;
                    pd     <= 1'b1;
                    rst    <= 1'b1;
                    locked <= 1'b0;
                    fail   <= 1'b0;
                    retry  <= '0;
                    cnt    <= '0;
                end else begin
                    unique case (state)
                        S_IDLE: begin
                            pd    <= 1'b1;
                            rst   <= 1'b1;
                            retry <= '0;
                            fail  <= 1'b0;
                            if (PLL_EN[i]) begin
                                state <= S_PD;
                                cnt   <= '0;
                            end
                        end
                        S_PD: begin
                            if (cnt == PD_LAST) begin
                                state <= S_RST;
                                pd    <= 1'b0;
                                cnt   <= '0;
                                tmo   <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        S_RST: begin
                            // Refclk loss parks the count at zero until it recovers.
                            if (rl[i]) begin
                                cnt <= '0;
                                tmo <= '0;
                            end else if (cnt == RST_LAST) begin
                                state <= S_WAIT;
                                rst   <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        S_WAIT, S_STABLE: begin
                            if (rl[i]) begin
                                state <= S_RST;
                                pd    <= 1'b0;
                                rst   <= 1'b1;
                                cnt   <= '0;
                                tmo   <= '0;
                            end else if (tmo == TMO_LAST) begin
                                state <= retry_state;
                                fail  <= at_max;
                                retry <= at_max ? retry : retry_inc;
                                pd    <= 1'b1;
                                rst   <= 1'b1;
                                cnt   <= '0;
                            end else begin
                                tmo <= tmo + TMO_W'(1);
                                if (state == S_WAIT) begin
                                    if (lk[i]) begin
                                        state <= S_STABLE;
                                        stab  <= '0;
                                    end
                                end else if (!lk[i]) begin
                                    state <= S_WAIT;
                                end else if (stab >= STB_LAST) begin
                                    state  <= S_LOCKED;
                                    locked <= 1'b1;
                                    retry  <= '0;
                                end else begin
                                    stab <= stab + STB_W'(1);
                                end
                            end
                        end
                        S_LOCKED: begin
                            if (rl[i]) begin
                                lost   <= 1'b1;
                                locked <= 1'b0;
                                state  <= S_RST;
                                pd     <= 1'b0;
                                rst    <= 1'b1;
                                cnt    <= '0;
                                tmo    <= '0;
                            end else if (!lk[i]) begin
                                lost   <= 1'b1;
                                locked <= 1'b0;
                                state  <= retry_state;
                                fail   <= at_max;
                                retry  <= at_max ? retry : retry_inc;
                                pd     <= 1'b1;
                                rst    <= 1'b1;
                                cnt    <= '0;
                            end
                        end
                        S_FAIL: begin
                            pd   <= 1'b1;
                            rst  <= 1'b1;
                            fail <= 1'b1;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end

        assign qpll_pd_out[i]         = pd;
        assign qpll_reset_out[i]      = rst;
        assign qpll_locked[i]         = locked;
        assign qpll_fail[i]           = fail;
        assign qpll_lost_pulse[i]     = lost;
        assign qpll_retry_cnt[4*i +: 4] = retry;
    end

    assign all_locked = (PLL_EN != '0) && (&(qpll_locked | ~PLL_EN));

endmodule
